mioc_reset_seq: RTL

MIOC_RESET_SEQ -- requirements
Module: mioc_reset_seq

---
 rtl/mioc_reset_seq.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mioc_reset_seq.sv
// MIOC reset sequencer.
// Synchronizes and debounces the ADAM reset switch and the game reset, then
// sequences the system, computer-mode and AdamNET resets out of a four-state
// FSM. RST_N is released a fixed stretch after the inputs go quiet, and
// NETRST_N follows a further fixed lag. POR_N overrides everything at once.
module mioc_reset_seq #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int STRETCH_CYC  = 16,
    parameter int NET_LAG      = 8
) (
    input  logic       B_PHI,
    input  logic       POR_N,
    input  logic       PBRST_N,
    input  logic       N_CVRST,
    output logic       RST_N,
    output logic       CPRST_N,
    output logic       NETRST_N,
    output logic [1:0] RST_CAUSE
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_HOLD    = 2'b01,
        ST_NETWAIT = 2'b10,
        ST_RUN     = 2'b11
    } state_t;

    localparam logic [3:0] DEB_LAST     = 4'(DEBOUNCE_CYC - 1);
    localparam logic [7:0] STRETCH_LAST = 8'(STRETCH_CYC - 1);
    localparam logic [7:0] NET_LAST     = 8'(NET_LAG - 1);

    // One debouncer step: returns {next debounced state, next count}.
    // The count saturates at its flip point, so it can never wrap.
    function automatic logic [4:0] debounce_step(input logic       sync,
                                                 input logic       deb,
                                                 input logic [3:0] cnt);
        logic [4:0] res;
        if (sync == deb) begin
            res = {deb, 4'd0};
        end else if (cnt >= DEB_LAST) begin
            res = {~deb, 4'd0};
        end else begin
            res = {deb, cnt + 4'd1};
        end
        return res;
    endfunction

    logic       pb_meta_r, pb_sync_r, cv_meta_r, cv_sync_r;
    logic       pb_deb_r, cv_deb_r;
    logic [3:0] pb_cnt_r, cv_cnt_r;
    logic       pb_deb_nxt_s, cv_deb_nxt_s;
    logic [3:0] pb_cnt_nxt_s, cv_cnt_nxt_s;
    logic       pb_press_s, cv_press_s, release_s;

    state_t     state_r, state_nxt_s;
    logic [7:0] cnt_r, cnt_nxt_s;
    logic [1:0] cause_r, cause_nxt_s;
    logic       rst_n_r, cprst_n_r, netrst_n_r;
    logic       rst_n_nxt_s, cprst_n_nxt_s, netrst_n_nxt_s;

    // Two-flop synchronizers for the asynchronous button inputs (idle high)
    always_ff @(posedge B_PHI or negedge POR_N) begin
        if (!POR_N) begin
            pb_meta_r <= 1'b1;
            pb_sync_r <= 1'b1;
            cv_meta_r <= 1'b1;
            cv_sync_r <= 1'b1;
        end else begin
            pb_meta_r <= PBRST_N;
            pb_sync_r <= pb_meta_r;
            cv_meta_r <= N_CVRST;
            cv_sync_r <= cv_meta_r;
        end
    end

    // Debouncer next-state and press/release detection
    always_comb begin
        {pb_deb_nxt_s, pb_cnt_nxt_s} = debounce_step(pb_sync_r, pb_deb_r, pb_cnt_r);
        {cv_deb_nxt_s, cv_cnt_nxt_s} = debounce_step(cv_sync_r, cv_deb_r, cv_cnt_r);
        // A press is the debounced level falling on this edge; release looks at
        // the post-edge levels so the FSM can leave ASSERT on the same edge.
        pb_press_s = pb_deb_r & ~pb_deb_nxt_s;
        cv_press_s = cv_deb_r & ~cv_deb_nxt_s;
        release_s  = pb_deb_nxt_s & cv_deb_nxt_s;
    end

    // Debouncer state and counters
    always_ff @(posedge B_PHI or negedge POR_N) begin
        if (!POR_N) begin
            pb_deb_r <= 1'b1;
            cv_deb_r <= 1'b1;
            pb_cnt_r <= 4'd0;
            cv_cnt_r <= 4'd0;
        end else begin
            pb_deb_r <= pb_deb_nxt_s;
            cv_deb_r <= cv_deb_nxt_s;
            pb_cnt_r <= pb_cnt_nxt_s;
            cv_cnt_r <= cv_cnt_nxt_s;
        end
    end

    // Sequencer next state, cycle count, cause and output levels
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cause_nxt_s = cause_r;
        case (state_r)
            ST_ASSERT: begin
                if (pb_press_s | cv_press_s) begin
                    cause_nxt_s = cause_r | {pb_press_s, cv_press_s};
                    cnt_nxt_s   = 8'd0;
                end else if (release_s) begin
                    state_nxt_s = ST_HOLD;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s   = 8'd0;
                end
            end
            ST_HOLD: begin
                if (pb_press_s | cv_press_s) begin
                    state_nxt_s = ST_ASSERT;
                    cause_nxt_s = cause_r | {pb_press_s, cv_press_s};
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r >= STRETCH_LAST) begin
                    state_nxt_s = ST_NETWAIT;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 8'd1;
                end
            end
            ST_NETWAIT: begin
                if (pb_press_s | cv_press_s) begin
                    state_nxt_s = ST_ASSERT;
                    cause_nxt_s = cause_r | {pb_press_s, cv_press_s};
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r >= NET_LAST) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s   = cnt_r + 8'd1;
                end
            end
            ST_RUN: begin
                if (pb_press_s | cv_press_s) begin
                    state_nxt_s = ST_ASSERT;
                    cause_nxt_s = {pb_press_s, cv_press_s};
                    cnt_nxt_s   = 8'd0;
                end else begin
                    cnt_nxt_s   = 8'd0;
                end
            end
            default: begin
                state_nxt_s = ST_ASSERT;
                cnt_nxt_s   = 8'd0;
            end
        endcase
        // Outputs follow the state being entered so they change on the same edge.
        rst_n_nxt_s    = (state_nxt_s == ST_NETWAIT) || (state_nxt_s == ST_RUN);
        netrst_n_nxt_s = (state_nxt_s == ST_RUN);
        // A game-only reset leaves the computer-mode side running.
        cprst_n_nxt_s  = rst_n_nxt_s || (cause_nxt_s == 2'b01);
    end

    // Sequencer state and registered outputs
    always_ff @(posedge B_PHI or negedge POR_N) begin
        if (!POR_N) begin
            state_r    <= ST_ASSERT;
            cnt_r      <= 8'd0;
            cause_r    <= 2'b00;
            rst_n_r    <= 1'b0;
            cprst_n_r  <= 1'b0;
            netrst_n_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            cause_r    <= cause_nxt_s;
            rst_n_r    <= rst_n_nxt_s;
            cprst_n_r  <= cprst_n_nxt_s;
            netrst_n_r <= netrst_n_nxt_s;
        end
    end

    assign RST_N     = rst_n_r;
    assign CPRST_N   = cprst_n_r;
    assign NETRST_N  = netrst_n_r;
    assign RST_CAUSE = cause_r;

endmodule
